dbus_arbiter: RTL and testbench

DBUS_ARBITER -- requirements
Module: dbus_arbiter

---
 rtl/dbus_arb_pkg.sv | 12 +
 rtl/dbus_arbiter_rr_pick.sv | 33 +++
 rtl/dbus_arbiter.sv | 118 +++++++++++
 tb/tb_dbus_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dbus_arb_pkg.sv
// rtl/dbus_arb_pkg.sv - shared state type and default sizing for the data-bus arbiter
package dbus_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    localparam int DEFAULT_NREQ    = 4;
    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/dbus_arbiter_rr_pick.sv
// rtl/dbus_arbiter_rr_pick.sv - combinational round-robin picker, first set request at or after start
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    int c;

    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        c      = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(start) + i;
            if (c >= N) begin
                c = c - N;
            end
            if (!valid && req[c]) begin
                valid     = 1'b1;
                onehot[c] = 1'b1;
                idx       = IW'(c);
            end
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - round-robin data-bus arbiter with lock and abort; optional watchdog via DBUS_ARB_TIMEOUT_EN
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int NREQ           = DEFAULT_NREQ,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic                    xfer_done,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   start;
    logic            pick_valid;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            release_ev;
    logic            new_grant;
    logic            timeout_hit;

    // The releasing owner sits at last_owner, so starting one past it puts it last.
    assign start = (last_q == IW'(NREQ - 1)) ? '0 : last_q + 1'b1;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .start  (start),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        last_d     = last_q;
        new_grant  = 1'b0;
        // Abort and done in the same cycle still form a single release.
        release_ev = (state_q == ARB_OWNED) &&
                     (!req[idx_q] || (xfer_done && !lock[idx_q]) || timeout_hit);
        if (state_q == ARB_IDLE || release_ev) begin
            if (pick_valid) begin
                state_d   = ARB_OWNED;
                grant_d   = pick_onehot;
                idx_d     = pick_idx;
                last_d    = pick_idx;
                new_grant = 1'b1;
            end else begin
                state_d = ARB_IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        end
    end

`ifdef DBUS_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        timeout_q;

    assign timeout_hit = (state_q == ARB_OWNED) && !xfer_done &&
                         (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (new_grant || xfer_done || state_q != ARB_OWNED) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYCLES > 0) ^ new_grant;
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign busy      = (state_q == ARB_OWNED);

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - scoreboard bench for dbus_arbiter with directed vectors
module tb_dbus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] lock = '0;
    logic       xfer_done = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout_err;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic       te;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    dbus_arbiter #(
        .NREQ           (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .lock        (lock),
        .xfer_done   (xfer_done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Monitor: compares every expectation due in the cycle just completed.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic ok;
            e = q.pop_front();
            n_cmp++;
            ok = (e.cyc == cyc) && (grant === e.g) && (busy === (|e.g)) &&
                 (timeout_err === e.te) && (!(|e.g) || grant_idx === idx_of(e.g));
            if (!ok) begin
                n_err++;
                $display("FAIL %s cyc=%0d: got grant=%b idx=%0d busy=%b terr=%b, need grant=%b idx=%0d busy=%b terr=%b (due cyc %0d)",
                         e.tag, cyc, grant, grant_idx, busy, timeout_err,
                         e.g, idx_of(e.g), |e.g, e.te, e.cyc);
            end
        end
    end

    task automatic step(input logic rs, input logic [3:0] r, input logic [3:0] l,
                        input logic xd, input logic [3:0] eg, input logic et,
                        input string tag);
        @(posedge clk);
        #1;
        rst       = rs;
        req       = r;
        lock      = l;
        xfer_done = xd;
        q.push_back('{cyc + 1, eg, et, tag});
    endtask

    task automatic do_reset();
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "reset");
    endtask

    initial begin
        // Basic handover without bubble
        do_reset();
        step(0, 4'b0101, 4'b0000, 0, 4'b0001, 0, "first_grant");
        step(0, 4'b0101, 4'b0000, 1, 4'b0100, 0, "handover_no_bubble");
        step(0, 4'b0100, 4'b0000, 0, 4'b0100, 0, "hold_owner2");
        step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "abort_to_idle");

        // Round-robin rotation with all requesting
        do_reset();
        step(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, "rr_g0");
        step(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, "rr_g0_hold");
        step(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, "rr_g0_hold");
        step(0, 4'b1111, 4'b0000, 1, 4'b0010, 0, "rr_g1");
        step(0, 4'b1111, 4'b0000, 0, 4'b0010, 0, "rr_g1_hold");
        step(0, 4'b1111, 4'b0000, 0, 4'b0010, 0, "rr_g1_hold");
        step(0, 4'b1111, 4'b0000, 1, 4'b0100, 0, "rr_g2");
        step(0, 4'b1111, 4'b0000, 0, 4'b0100, 0, "rr_g2_hold");
        step(0, 4'b1111, 4'b0000, 0, 4'b0100, 0, "rr_g2_hold");
        step(0, 4'b1111, 4'b0000, 1, 4'b1000, 0, "rr_g3");
        step(0, 4'b1111, 4'b0000, 0, 4'b1000, 0, "rr_g3_hold");
        step(0, 4'b1111, 4'b0000, 0, 4'b1000, 0, "rr_g3_hold");
        step(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, "rr_wrap_g0");
        step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "rr_idle");

        // Lock retains owner across transfers
        do_reset();
        step(0, 4'b0100, 4'b0000, 0, 4'b0100, 0, "lock_g2");
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b1111, 4'b0100, 1, 4'b0100, 0, "lock_keep_done");
            step(0, 4'b1111, 4'b0100, 0, 4'b0100, 0, "lock_keep_gap");
        end
        step(0, 4'b1111, 4'b0000, 0, 4'b0100, 0, "unlock_hold");
        step(0, 4'b1111, 4'b0000, 1, 4'b1000, 0, "unlock_release");
        step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "lock_idle");

        // Abort, then stray xfer_done in idle
        do_reset();
        step(0, 4'b0010, 4'b0000, 0, 4'b0010, 0, "abort_g1");
        step(0, 4'b0010, 4'b0000, 0, 4'b0010, 0, "abort_g1_hold");
        step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "abort_busy0");
        step(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, "stray_done");
        step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "stray_after");

        // Done and abort together form one release
        do_reset();
        step(0, 4'b0011, 4'b0000, 0, 4'b0001, 0, "dual_g0");
        step(0, 4'b0010, 4'b0000, 1, 4'b0010, 0, "dual_single_release");
        step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "dual_idle");

        // Sole requester is re-granted after its own release
        do_reset();
        step(0, 4'b0001, 4'b0000, 0, 4'b0001, 0, "solo_g0");
        step(0, 4'b0001, 4'b0000, 1, 4'b0001, 0, "solo_regrant");
        step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "solo_idle");

        // Reset while owned, then priority restarts at requester 0
        do_reset();
        step(0, 4'b0100, 4'b0000, 0, 4'b0100, 0, "rst_g2");
        step(1, 4'b0100, 4'b0000, 0, 4'b0000, 0, "rst_drop");
        step(0, 4'b1001, 4'b0000, 0, 4'b0001, 0, "rst_prio0");
        step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "rst_idle");

        // Watchdog
        do_reset();
        step(0, 4'b0001, 4'b0000, 0, 4'b0001, 0, "to_g0");
`ifdef DBUS_ARB_TIMEOUT_EN
        for (int i = 1; i <= 7; i++) begin
            step(0, 4'b1001, 4'b0000, 0, 4'b0001, 0, "to_wait");
        end
        step(0, 4'b1001, 4'b0000, 0, 4'b1000, 1, "to_fire");
        step(0, 4'b1001, 4'b0000, 0, 4'b1000, 0, "to_single_pulse");
`else
        for (int i = 0; i < 1000; i++) begin
            step(0, 4'b1001, 4'b0000, 0, 4'b0001, 0, "no_to_hold");
        end
`endif
        step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "to_idle");

        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
